// File: rtl/neo_sample_source.sv
// neo_sample_source
//   Streams one frame of raw samples out of a synchronous-read sample RAM and
//   into the NEO calculator's sample port.
//
//   A 2-entry FIFO absorbs the RAM's one-cycle read latency. A read is only
//   issued when the sample it returns is guaranteed a free FIFO slot, so
//   backpressure on s_ready can never overflow the FIFO.
//
//   Stream handshake: a sample moves when s_valid and s_ready are both high at
//   a rising Clk edge. Once s_valid is raised, s_data and s_last stay stable
//   until that handshake happens.
//
// Ports
//   Clk        system clock, rising edge
//   reset      synchronous, active-high; aborts a frame immediately
//   start      one-cycle frame request, only honoured in IDLE
//   frame_len  samples in the frame, captured with start
//   busy       high in RUN and FINISH
//   done       one-cycle pulse after the final sample is accepted
//   mem_rd_en  sample RAM read enable
//   mem_addr   sample RAM read address (holds while mem_rd_en is low)
//   mem_rdata  RAM read data, valid the cycle after mem_rd_en
//   s_data     sample to the calculator (FIFO head)
//   s_valid    FIFO non-empty
//   s_ready    calculator accepts the sample
//   s_last     marks the final sample of the frame
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 FINISH)
module neo_sample_source #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] frame_len,
  output logic         busy,
  output logic         done,
  output logic         mem_rd_en,
  output logic [M-1:0] mem_addr,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         s_last,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t       state;
  logic [M-1:0] len_r;
  logic [M-1:0] issue_cnt;
  logic [M-1:0] acc_cnt;
  logic [M-1:0] addr_r;
  logic         inflight;
  logic [1:0]   occ;
  logic [N-1:0] fifo0;
  logic [N-1:0] fifo1;

  logic         pop;
  logic         issue;
  logic         last_acc;
  logic [2:0]   pending;

  assign s_valid = (occ != 2'd0);
  assign s_data  = fifo0;
  assign pop     = s_valid & s_ready;

  // Samples that will occupy the FIFO after this edge if no new read is made:
  // current contents plus the read returning now, minus the one leaving.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign issue     = (state == RUN) && (issue_cnt < len_r) && (pending < 3'd2);
  assign mem_rd_en = issue;
  assign mem_addr  = issue ? issue_cnt : addr_r;

  assign last_acc  = (acc_cnt == (len_r - M'(1)));
  assign s_last    = s_valid & last_acc;

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign dbg_state = state;

  // Frame control and counters
  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      len_r     <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      addr_r    <= '0;
    end else begin
      if (issue) begin
        addr_r <= issue_cnt;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_r     <= frame_len;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            state     <= (frame_len != '0) ? RUN : FINISH;
          end
        end
        RUN: begin
          if (issue) begin
            issue_cnt <= issue_cnt + M'(1);
          end
          if (pop) begin
            acc_cnt <= acc_cnt + M'(1);
            if (last_acc) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read-return tracking and the 2-entry FIFO (fifo0 is always the head)
  always_ff @(posedge Clk) begin
    if (reset) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      fifo0    <= '0;
      fifo1    <= '0;
    end else begin
      inflight <= issue;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            fifo0 <= mem_rdata;
          end else begin
            fifo1 <= mem_rdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new sample lands behind whatever remains.
          if (occ == 2'd1) begin
            fifo0 <= mem_rdata;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neo_sample_source.sv
module tb_neo_sample_source;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [15:0] frame_len;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  neo_sample_source #(.N(16), .M(16)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .dbg_state (dbg_state)
  );

  // ---------------- sample RAM model (1-cycle read) ----------------
  logic [15:0] ram [0:63];
  initial mem_rdata = '0;
  always @(posedge Clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr[5:0]];
  end

  // ---------------- s_ready driver ----------------
  // 0: always 1, 1: random, 2: fixed pattern 1,0,0,1,0,1..., 3: held 0
  int ready_mode = 0;
  logic pat [0:5];
  initial begin
    int pi;
    pi = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    s_ready = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0: s_ready = 1'b1;
        1: s_ready = 1'($urandom_range(0, 1));
        2: begin s_ready = pat[pi % 6]; pi++; end
        default: s_ready = 1'b0;
      endcase
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] exp_q[$];
  int   issued = 0;
  int   accepted = 0;
  int   mlen = 0;
  int   done_cnt = 0;
  bit   mon_en = 0;
  bit   last_hs_prev = 0;
  bit   prev_stall = 0;
  bit   addr_valid = 0;
  logic [15:0] prev_data;
  logic [15:0] prev_addr;

  always @(negedge Clk) begin
    logic hs;
    logic [15:0] e;
    if (mon_en && !reset) begin
      hs = s_valid && s_ready;
      if (mem_rd_en) begin
        // Reads outstanding (issued, not yet accepted) must leave room for this one.
        check("rd_room", 32'((issued - accepted - int'(hs)) < 2), 32'(1));
        check("rd_addr", 32'(mem_addr), 32'(issued));
        check("rd_range", 32'(issued < mlen), 32'(1));
        issued++;
      end else if (addr_valid) begin
        check("addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
      if (prev_stall) begin
        check("stall_valid", 32'(s_valid), 32'(1));
        check("stall_data", 32'(s_data), 32'(prev_data));
      end
      check("s_last", 32'(s_last), 32'(s_valid && (accepted == mlen - 1)));
      if (mlen != 0) check("done_timing", 32'(done), 32'(last_hs_prev));
      if (hs) begin
        check("sample_avail", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("s_data", 32'(s_data), 32'(e));
        end
        accepted++;
      end
      if (done) done_cnt++;
      last_hs_prev = hs && s_last;
      prev_stall   = s_valid && !s_ready;
      prev_data    = s_data;
      prev_addr    = mem_addr;
      addr_valid   = 1;
    end else begin
      addr_valid   = 0;
      prev_stall   = 0;
      last_hs_prev = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_model(input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(ram[i]);
    issued   = 0;
    accepted = 0;
    mlen     = len;
  endtask

  task automatic pulse_start(input int len);
    @(posedge Clk); #1;
    start = 1'b1;
    frame_len = 16'(len);
    @(posedge Clk); #1;
    start = 1'b0;
    frame_len = 16'($urandom);
  endtask

  task automatic run_frame(input int len, input bit inject);
    int k;
    int d0;
    d0 = done_cnt;
    load_model(len);
    pulse_start(len);
    if (len == 0) begin
      @(negedge Clk);
      check("z_done", 32'(done), 32'(1));
      check("z_busy", 32'(busy), 32'(1));
      check("z_rd", 32'(mem_rd_en), 32'(0));
      check("z_valid", 32'(s_valid), 32'(0));
    end else begin
      k = 0;
      do begin @(negedge Clk); k++; end while (!s_valid && k < 20);
      check("valid_latency", 32'(k), 32'(3));
      if (inject) pulse_start(3);
      k = 0;
      while (!done && k < 2000) begin @(negedge Clk); k++; end
      check("done_seen", 32'(done), 32'(1));
      check("busy_with_done", 32'(busy), 32'(1));
    end
    @(negedge Clk);
    check("done_fell", 32'(done), 32'(0));
    check("busy_fell", 32'(busy), 32'(0));
    check("sample_count", 32'(accepted), 32'(len));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("done_pulses", 32'(done_cnt - d0), 32'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int hs;
    int len;
    reset = 1'b1;
    start = 1'b0;
    frame_len = '0;
    for (int i = 0; i < 64; i++) ram[i] = 16'(i * 3);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rd_en", 32'(mem_rd_en), 32'(0));
    check("rst_addr", 32'(mem_addr), 32'(0));
    check("rst_valid", 32'(s_valid), 32'(0));
    check("rst_data", 32'(s_data), 32'(0));
    check("rst_last", 32'(s_last), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    reset = 1'b0;
    mon_en = 1;

    // frame of 8, RAM[i]=i*3, full throughput
    ready_mode = 0;
    run_frame(8, 0);

    // frame of 6 under a stall pattern, random RAM contents
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    @(negedge Clk); ready_mode = 2;
    run_frame(6, 0);

    // empty frame
    @(negedge Clk); ready_mode = 0;
    run_frame(0, 0);

    // start during RUN is ignored
    run_frame(5, 1);
    repeat (6) begin
      @(negedge Clk);
      check("idle_after_inject", 32'(s_valid | busy), 32'(0));
    end

    // random frames with random backpressure
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
      len = $urandom_range(1, 24);
      @(negedge Clk); ready_mode = 1;
      run_frame(len, 0);
    end

    // reset mid-frame
    @(negedge Clk); ready_mode = 1;
    load_model(10);
    pulse_start(10);
    hs = 0;
    k = 0;
    while (hs < 2 && k < 500) begin
      @(negedge Clk);
      if (s_valid && s_ready) hs++;
      k++;
    end
    check("reset_pre_hs", 32'(hs), 32'(2));
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    reset = 1'b1;
    mon_en = 0;
    @(posedge Clk); #1;
    reset = 1'b0;
    @(negedge Clk);
    check("abort_valid", 32'(s_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    exp_q.delete();
    mon_en = 1;
    ready_mode = 0;
    run_frame(4, 0);

    // single sample 8000 held under backpressure
    ram[0] = 16'h8000;
    @(negedge Clk); ready_mode = 3;
    load_model(1);
    pulse_start(1);
    k = 0;
    do begin @(negedge Clk); k++; end while (!s_valid && k < 20);
    check("one_latency", 32'(k), 32'(3));
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 32'(s_valid), 32'(1));
      check("hold_last", 32'(s_last), 32'(1));
      check("hold_data", 32'(s_data), 32'(16'h8000));
      if (c < 4) @(negedge Clk);
    end
    ready_mode = 0;
    k = 0;
    while (!done && k < 20) begin @(negedge Clk); k++; end
    // s_ready rises after the next edge, handshake on the one after, done visible at the following negedge
    check("one_done_delay", 32'(k), 32'(2));
    @(negedge Clk);
    check("one_count", 32'(accepted), 32'(1));
    check("one_busy", 32'(busy), 32'(0));

    repeat (2) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neo_sample_source.md
Name: neo_sample_source

Overview:
- Streams raw signal samples from the sample memory into the NEO calculator's input port.
- Acts as the writer/producer end of the calculator's sample interface: addresses a synchronous-read sample RAM, absorbs its read latency, and presents samples over a valid/ready stream with frame delimiting.
- Sits between the sample RAM and NEOcalculator; frames are launched by the control sequencer via start/done.

Parameters:
- N, 16, sample width in bits (two's complement; matches calculator N).
- M, 16, address width in bits; also the width of frame_len.

Ports:
- Clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to stream one frame; sampled only in IDLE.
- frame_len  input  M  number of samples in the frame; captured when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the frame is complete.
- mem_rd_en  output  1  sample RAM read enable.
- mem_addr  output  M  sample RAM read address.
- mem_rdata  input  N  RAM read data; valid exactly 1 cycle after mem_rd_en.
- s_data  output  N  sample to the calculator.
- s_valid  output  1  s_data valid.
- s_ready  input  1  calculator accepts the sample.
- s_last  output  1  high with the final sample of the frame.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, FIFO is empty, and the in-flight flag is cleared. Reset mid-frame aborts immediately. A read already in flight is discarded, and no done pulse is issued.
- FSM states and transitions:
  - IDLE: start=1 with frame_len>0 goes to RUN. frame_len is latched into len_r, and the issue counter and accept counter are zeroed.
  - IDLE: start=1 with frame_len=0 goes to FINISH. No reads are issued.
  - RUN: when the accept counter reaches len_r (the last handshake occurs), go to FINISH.
  - FINISH: done=1 for exactly one cycle, then return to IDLE.
- busy=1 in RUN and FINISH. start is ignored in RUN and FINISH.
- Read issue:
  - In RUN, mem_rd_en=1 with mem_addr=issue_cnt when issue_cnt<len_r and (occ + inflight - pop) < 2.
  - occ is the 2-entry FIFO occupancy; pop is the s_valid&s_ready handshake in the same cycle.
  - issue_cnt increments on each read. Addresses run 0..len_r-1 with no wrap.
  - mem_addr holds its last value when mem_rd_en=0.
- Read return: the inflight flag is set on the cycle after mem_rd_en. In that cycle mem_rdata is pushed into the FIFO at the clock edge.
- Output:
  - s_valid = FIFO non-empty; s_data = FIFO head. Both are registered, so the head is stable while s_valid&!s_ready.
  - s_last = s_valid & (accept_cnt == len_r-1).
  - The accept counter increments on each handshake.
- Latency: start is sampled at edge E0. mem_rd_en=1 (addr 0) in cycle E0+1. Data is pushed at E0+2. s_valid first rises in cycle E0+3, i.e. 3 cycles after start.
- Throughput: with s_ready held at 1, one sample per cycle in steady state.
- Backpressure: the FIFO never overflows. A simultaneous push and pop is legal and occupancy is unchanged. A pop from empty is impossible because s_valid gates it.
- done timing: done is asserted in the cycle after the handshake of the s_last sample. busy falls together with done's falling edge, i.e. busy=0 the cycle after done.
- frame_len=2^M-1 is legal. Counters are M bits wide and compare against len_r, so no overflow occurs.

Test Plan:
- Reset, then start with frame_len=8, RAM[i]=i*3, s_ready=1:
  - s_valid rises 3 cycles after start.
  - s_data = 0,3,...,21 on consecutive cycles.
  - s_last only on 21.
  - done pulses 1 cycle after the 21 handshake.
- frame_len=6 with s_ready toggling 1,0,0,1,0,1...:
  - All 6 samples are delivered in order with none dropped or duplicated.
  - s_data is stable while stalled.
  - mem_rd_en is never asserted when occ+inflight would exceed 2.
- start with frame_len=0:
  - No mem_rd_en and no s_valid.
  - done is high exactly one cycle, 1 cycle after start; busy is high for that cycle only.
- Assert start again during RUN with frame_len=3 while the first frame has frame_len=5: it is ignored, and exactly 5 samples plus one done are produced.
- Assert reset 2 cycles after the 2nd handshake of a frame_len=10 frame:
  - Next cycle: s_valid, busy and done are all 0.
  - A fresh start with frame_len=4 delivers RAM[0..3] correctly.
- frame_len=1, RAM[0]=16'h8000 with s_ready=0 for 5 cycles: s_valid=1, s_last=1 and s_data=16'h8000 are held, and done occurs 1 cycle after s_ready rises.
